bridge_scheduler: RTL and testbench

- Central sequencing engine of the AXI2APB bridge.
- Accepts AXI read (AR) and write (AW) address requests and arbitrates between them round-robin.
- Breaks each granted burst into single APB transfers, generating per-beat address, direction and push strobes for the read-data and write-response buffers.
- Sits between the AXI-side channel buffers and the APB master FSM.

---
 rtl/bridge_scheduler.sv | 196 +++++++++++++++++++
 tb/tb_bridge_scheduler.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bridge_scheduler.sv
// AXI2APB bridge scheduler: round-robin AR/AW arbitration, bursts split into APB beats.
// Optional watchdog on stuck APB transfers: define BRIDGE_SCHED_TIMEOUT_EN.
module bridge_scheduler #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ar_valid,
  output logic                  ar_ready,
  input  logic [ADDR_WIDTH-1:0] ar_addr,
  input  logic [3:0]            ar_len,
  input  logic [2:0]            ar_size,
  input  logic [1:0]            ar_burst,
  input  logic                  aw_valid,
  output logic                  aw_ready,
  input  logic [ADDR_WIDTH-1:0] aw_addr,
  input  logic [3:0]            aw_len,
  input  logic [2:0]            aw_size,
  input  logic [1:0]            aw_burst,
  input  logic                  w_avail,
  input  logic                  r_space,
  input  logic                  b_space,
  output logic                  apb_start,
  output logic                  apb_write,
  output logic [ADDR_WIDTH-1:0] apb_addr,
  input  logic                  apb_done,
  input  logic                  apb_slverr,
  output logic                  r_push,
  output logic [1:0]            r_resp,
  output logic                  r_last,
  output logic                  w_pop,
  output logic                  b_push,
  output logic [1:0]            b_resp,
`ifdef BRIDGE_SCHED_TIMEOUT_EN
  output logic                  timeout_evt,
`endif
  output logic                  busy
);

  localparam logic [2:0] MAXSZ = 3'($clog2(DATA_WIDTH/8));

  typedef enum logic [2:0] {
    IDLE, RD_WAIT, RD_XFER, WR_WAIT, WR_XFER, WR_RESP
  } state_t;

  state_t                state, nxt;
  logic                  last_wr;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [3:0]            cnt_q;
  logic [2:0]            size_q;
  logic                  fixed_q;
  logic                  err_q;
  logic                  grant_rd, grant_wr;
  logic                  xfer, done, derr, tmo;
  logic [ADDR_WIDTH-1:0] step;

  function automatic logic [2:0] clamp(input logic [2:0] s);
    return (s > MAXSZ) ? MAXSZ : s;
  endfunction

  assign grant_rd = (state == IDLE) && ar_valid
                  && (!aw_valid || last_wr);
  assign grant_wr = (state == IDLE) && aw_valid
                  && (!ar_valid || !last_wr);
  assign xfer = (state == RD_XFER) || (state == WR_XFER);
  assign step = ADDR_WIDTH'(1) << size_q;
  assign apb_addr = addr_q;
  assign busy = (state != IDLE);

`ifdef BRIDGE_SCHED_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tcnt;

  assign tmo = xfer && !apb_done
             && (tcnt == TW'(TIMEOUT_CYCLES - 1));
  assign timeout_evt = tmo;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      tcnt <= '0;
    else if (apb_start)
      tcnt <= '0;
    else if (xfer && !done)
      tcnt <= tcnt + TW'(1);
  end
`else
  assign tmo = 1'b0;
`endif

  // A watchdog expiry completes the beat with an error.
  assign done = xfer && (apb_done || tmo);
  assign derr = apb_done ? apb_slverr : 1'b1;

  always_comb begin
    nxt       = state;
    ar_ready  = 1'b0;
    aw_ready  = 1'b0;
    apb_start = 1'b0;
    apb_write = 1'b0;
    r_push    = 1'b0;
    r_resp    = 2'b00;
    r_last    = 1'b0;
    w_pop     = 1'b0;
    b_push    = 1'b0;
    b_resp    = 2'b00;
    unique case (state)
      IDLE: begin
        unique case (1'b1)
          grant_rd: begin
            ar_ready = 1'b1;
            nxt      = RD_WAIT;
          end
          grant_wr: begin
            aw_ready = 1'b1;
            nxt      = WR_WAIT;
          end
          default: ;
        endcase
      end
      RD_WAIT: begin
        if (r_space) begin
          apb_start = 1'b1;
          nxt       = RD_XFER;
        end
      end
      RD_XFER: begin
        if (done) begin
          r_push = 1'b1;
          r_resp = {derr, 1'b0};
          r_last = (cnt_q == 4'd0);
          nxt    = (cnt_q == 4'd0) ? IDLE : RD_WAIT;
        end
      end
      WR_WAIT: begin
        apb_write = 1'b1;
        if (w_avail) begin
          apb_start = 1'b1;
          w_pop     = 1'b1;
          nxt       = WR_XFER;
        end
      end
      WR_XFER: begin
        apb_write = 1'b1;
        if (done)
          nxt = (cnt_q == 4'd0) ? WR_RESP : WR_WAIT;
      end
      WR_RESP: begin
        if (b_space) begin
          b_push = 1'b1;
          b_resp = {err_q, 1'b0};
          nxt    = IDLE;
        end
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      last_wr <= 1'b1;
      addr_q  <= '0;
      cnt_q   <= '0;
      size_q  <= '0;
      fixed_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state <= nxt;
      if (ar_ready) begin
        addr_q  <= ar_addr;
        cnt_q   <= ar_len;
        size_q  <= clamp(ar_size);
        fixed_q <= (ar_burst == 2'b00);
        last_wr <= 1'b0;
      end else if (aw_ready) begin
        addr_q  <= aw_addr;
        cnt_q   <= aw_len;
        size_q  <= clamp(aw_size);
        fixed_q <= (aw_burst == 2'b00);
        last_wr <= 1'b1;
      end
      if (done && cnt_q != 4'd0) begin
        cnt_q <= cnt_q - 4'd1;
        if (!fixed_q)
          addr_q <= addr_q + step;
      end
      if (done && state == WR_XFER)
        err_q <= err_q | derr;
      else if (b_push)
        err_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bridge_scheduler.sv
// Scoreboard bench for bridge_scheduler with a simple APB slave model.
// Timeout case built only when BRIDGE_SCHED_TIMEOUT_EN is defined.
module tb_bridge_scheduler;

  logic        clk, rst_n;
  logic        ar_valid, ar_ready, aw_valid, aw_ready;
  logic [31:0] ar_addr, aw_addr, apb_addr;
  logic [3:0]  ar_len, aw_len;
  logic [2:0]  ar_size, aw_size;
  logic [1:0]  ar_burst, aw_burst;
  logic        w_avail, r_space, b_space;
  logic        apb_start, apb_write, apb_done, apb_slverr;
  logic        r_push, r_last, w_pop, b_push, busy;
  logic [1:0]  r_resp, b_resp;
`ifdef BRIDGE_SCHED_TIMEOUT_EN
  logic        timeout_evt;
`endif

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int start_cyc = 0;
  int tmo_cyc = 0;
  int n_tmo = 0;

  logic [32:0] exp_apb[$];
  logic [2:0]  exp_r[$];
  logic [1:0]  exp_b[$];
  bit          exp_g[$];
  logic [8:0]  slv_q[$];

  bridge_scheduler #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .ar_valid(ar_valid), .ar_ready(ar_ready),
    .ar_addr(ar_addr), .ar_len(ar_len),
    .ar_size(ar_size), .ar_burst(ar_burst),
    .aw_valid(aw_valid), .aw_ready(aw_ready),
    .aw_addr(aw_addr), .aw_len(aw_len),
    .aw_size(aw_size), .aw_burst(aw_burst),
    .w_avail(w_avail), .r_space(r_space), .b_space(b_space),
    .apb_start(apb_start), .apb_write(apb_write),
    .apb_addr(apb_addr), .apb_done(apb_done),
    .apb_slverr(apb_slverr),
    .r_push(r_push), .r_resp(r_resp), .r_last(r_last),
    .w_pop(w_pop), .b_push(b_push), .b_resp(b_resp),
`ifdef BRIDGE_SCHED_TIMEOUT_EN
    .timeout_evt(timeout_evt),
`endif
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    logic [32:0] ea;
    logic [2:0]  er;
    logic [1:0]  eb;
    if (rst_n) begin
      if (ar_ready || aw_ready)
        chk("ready_busy", 64'(busy), 0);
      if ((ar_valid && ar_ready) || (aw_valid && aw_ready)) begin
        if (exp_g.size() == 0) chk("grant_unexp", 1, 0);
        else chk("grant", 64'(aw_ready), 64'(exp_g.pop_front()));
      end
      if (apb_start) begin
        start_cyc = cyc;
        chk("w_pop", 64'(w_pop), 64'(apb_write));
        if (exp_apb.size() == 0) chk("start_unexp", 1, 0);
        else begin
          ea = exp_apb.pop_front();
          chk("apb_addr", 64'(apb_addr), 64'(ea[31:0]));
          chk("apb_write", 64'(apb_write), 64'(ea[32]));
        end
      end
      if (w_pop && !apb_start) chk("w_pop_alone", 1, 0);
      if (r_push) begin
        if (exp_r.size() == 0) chk("r_unexp", 1, 0);
        else begin
          er = exp_r.pop_front();
          chk("r_resp", 64'(r_resp), 64'(er[2:1]));
          chk("r_last", 64'(r_last), 64'(er[0]));
        end
      end
      if (b_push) begin
        if (exp_b.size() == 0) chk("b_unexp", 1, 0);
        else begin
          eb = exp_b.pop_front();
          chk("b_resp", 64'(b_resp), 64'(eb));
        end
      end
`ifdef BRIDGE_SCHED_TIMEOUT_EN
      if (timeout_evt) begin
        n_tmo++;
        tmo_cyc = cyc;
      end
`endif
    end
  end

  // APB slave: per-beat {err, latency}; latency 0 = never respond
  initial begin
    logic [8:0] ent;
    forever begin
      @(negedge clk);
      if (rst_n && apb_start) begin
        ent = (slv_q.size() != 0) ? slv_q.pop_front() : 9'h002;
        if (ent[7:0] != 8'd0) begin
          repeat (int'(ent[7:0]) - 1) @(posedge clk);
          #1;
          apb_done = 1'b1;
          apb_slverr = ent[8];
          @(posedge clk);
          #1;
          apb_done = 1'b0;
          apb_slverr = 1'b0;
        end
      end
    end
  end

  task automatic req(input bit wr, input logic [31:0] a,
                     input logic [3:0] l, input logic [2:0] s,
                     input logic [1:0] b);
    bit got = 0;
    @(posedge clk);
    #1;
    if (wr) begin
      aw_addr = a; aw_len = l; aw_size = s; aw_burst = b;
      aw_valid = 1'b1;
    end else begin
      ar_addr = a; ar_len = l; ar_size = s; ar_burst = b;
      ar_valid = 1'b1;
    end
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (wr ? aw_ready : ar_ready) begin
        got = 1;
        break;
      end
    end
    @(posedge clk);
    #1;
    ar_valid = 1'b0;
    aw_valid = 1'b0;
    if (!got) chk("req_handshake", 0, 1);
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (!busy && exp_apb.size() == 0 && exp_r.size() == 0
          && exp_b.size() == 0 && exp_g.size() == 0) begin
        ok = 1;
        break;
      end
    end
    chk("drain", 64'(ok), 1);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    int hs;
    rst_n = 1'b0;
    ar_valid = 0; aw_valid = 0;
    ar_addr = 0; ar_len = 0; ar_size = 0; ar_burst = 0;
    aw_addr = 0; aw_len = 0; aw_size = 0; aw_burst = 0;
    w_avail = 1; r_space = 1; b_space = 1;
    apb_done = 0; apb_slverr = 0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_start", 64'(apb_start), 0);
    chk("rst_addr", 64'(apb_addr), 0);
    chk("rst_ready", 64'({ar_ready, aw_ready}), 0);
    chk("rst_push", 64'({r_push, w_pop, b_push}), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Single read
    exp_g.push_back(0);
    exp_apb.push_back({1'b0, 32'h1000});
    exp_r.push_back({2'b00, 1'b1});
    req(0, 32'h1000, 4'd0, 3'd2, 2'b01);
    wait_idle();
    chk("rd_busy", 64'(busy), 0);

    // INCR write burst, error on beat 2
    slv_q = '{9'h002, 9'h102, 9'h002, 9'h002};
    exp_g.push_back(1);
    for (int i = 0; i < 4; i++)
      exp_apb.push_back({1'b1, 32'h2000 + 32'(4 * i)});
    exp_b.push_back(2'b10);
    req(1, 32'h2000, 4'd3, 3'd2, 2'b01);
    wait_idle();

    // Arbitration with both requests held
    do_reset();
    exp_g = '{0, 1, 0};
    exp_apb = '{{1'b0, 32'h10}, {1'b1, 32'h20}, {1'b0, 32'h10}};
    exp_r = '{3'b001, 3'b001};
    exp_b.push_back(2'b00);
    @(posedge clk);
    #1;
    ar_addr = 32'h10; ar_len = 0; ar_size = 2; ar_burst = 1;
    aw_addr = 32'h20; aw_len = 0; aw_size = 2; aw_burst = 1;
    ar_valid = 1; aw_valid = 1;
    hs = 0;
    for (int i = 0; i < 300 && hs < 3; i++) begin
      @(negedge clk);
      if ((ar_valid && ar_ready) || (aw_valid && aw_ready)) hs++;
    end
    @(posedge clk);
    #1 ar_valid = 0; aw_valid = 0;
    chk("arb_grants", 64'(hs), 3);
    wait_idle();

    // Backpressure with FIXED burst
    r_space = 0;
    exp_g.push_back(0);
    exp_apb = '{{1'b0, 32'h3000}, {1'b0, 32'h3000}};
    exp_r = '{3'b000, 3'b001};
    req(0, 32'h3000, 4'd1, 3'd2, 2'b00);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_start", 64'(apb_start), 0);
    end
    @(posedge clk);
    #1 r_space = 1;
    wait_idle();

    // Size clamp to 2, WRAP as INCR, SLVERR on first read beat
    slv_q = '{9'h103, 9'h002};
    exp_g.push_back(0);
    exp_apb = '{{1'b0, 32'h100}, {1'b0, 32'h104}};
    exp_r = '{3'b100, 3'b001};
    req(0, 32'h100, 4'd1, 3'd3, 2'b10);
    wait_idle();

    // Address wrap, reset during beat 2
    slv_q = '{9'h002, 9'h000};
    exp_g.push_back(1);
    exp_apb = '{{1'b1, 32'hFFFF_FFFC}, {1'b1, 32'h0}};
    req(1, 32'hFFFF_FFFC, 4'd1, 3'd2, 2'b01);
    for (int i = 0; i < 50 && exp_apb.size() != 0; i++)
      @(negedge clk);
    chk("wrap_beats", 64'(exp_apb.size()), 0);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_busy", 64'(busy), 0);
    chk("abort_out",
        64'({apb_start, apb_write, w_pop, b_push, r_push}), 0);
    chk("abort_addr", 64'(apb_addr), 0);
    repeat (3) begin
      @(negedge clk);
      chk("abort_bpush", 64'(b_push), 0);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("abort_idle", 64'(busy), 0);

`ifdef BRIDGE_SCHED_TIMEOUT_EN
    // Watchdog: slave never answers
    slv_q = '{9'h000};
    n_tmo = 0;
    exp_g.push_back(0);
    exp_apb.push_back({1'b0, 32'h40});
    exp_r.push_back({2'b10, 1'b1});
    req(0, 32'h40, 4'd0, 3'd2, 2'b01);
    wait_idle();
    chk("tmo_count", 64'(n_tmo), 1);
    chk("tmo_latency", 64'(tmo_cyc - start_cyc), 8);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
